// File: rtl/video_vram_arbiter.sv
// Two-port VRAM arbiter: video line fetch (pb) has priority over the CPU write buffer (pa).
// Define VIDEO_VRAM_ARBITER_STARVE_GUARD_EN to force a pa grant after BURST_LIMIT pb grants.
module video_vram_arbiter #(
  parameter int unsigned BURST_LIMIT = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  input  logic        i_pb_request,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  output logic        o_mem_request,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  if (BURST_LIMIT < 1 || BURST_LIMIT > 255) begin : g_bad_limit
    $error("BURST_LIMIT must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t      state_q = IDLE;
  state_t      state_d;
  logic [31:0] pa_rdata_q = '0;
  logic [31:0] pb_rdata_q = '0;
  logic        pa_ready;
  logic        pb_ready;
  logic        guard_force;
  logic        grant_pa;

`ifdef VIDEO_VRAM_ARBITER_STARVE_GUARD_EN
  logic [7:0] guard_q = '0;

  assign guard_force = i_pa_request && (guard_q == 8'(BURST_LIMIT));

  // Counts pb grants won against a waiting pa; only IDLE cycles make grants.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      guard_q <= '0;
    end else if (state_q == IDLE) begin
      if (!i_pa_request || grant_pa) begin
        guard_q <= '0;
      end else if (i_pb_request) begin
        guard_q <= guard_q + 8'd1;
      end
    end
  end
`else
  assign guard_force = 1'b0;
`endif

  assign grant_pa = i_pa_request && (!i_pb_request || guard_force);

  always_comb begin
    state_d       = state_q;
    o_mem_request = 1'b0;
    o_mem_rw      = 1'b0;
    o_mem_address = '0;
    o_mem_wdata   = '0;
    pa_ready      = 1'b0;
    pb_ready      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_pa) begin
          state_d = GRANT_A;
        end else if (i_pb_request) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        o_mem_request = i_pa_request;
        o_mem_rw      = i_pa_rw;
        o_mem_address = i_pa_address;
        o_mem_wdata   = i_pa_wdata;
        pa_ready      = i_pa_request && i_mem_ready;
        if (!i_pa_request || i_mem_ready) begin
          state_d = IDLE;
        end
      end
      GRANT_B: begin
        o_mem_request = i_pb_request;
        o_mem_address = i_pb_address;
        pb_ready      = i_pb_request && i_mem_ready;
        if (!i_pb_request || i_mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      pa_rdata_q <= '0;
      pb_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (pa_ready) begin
        pa_rdata_q <= i_mem_rdata;
      end
      if (pb_ready) begin
        pb_rdata_q <= i_mem_rdata;
      end
    end
  end

  // Read data is passed through during the owner's ready cycle, held otherwise.
  assign o_pa_ready = pa_ready;
  assign o_pb_ready = pb_ready;
  assign o_pa_rdata = pa_ready ? i_mem_rdata : pa_rdata_q;
  assign o_pb_rdata = pb_ready ? i_mem_rdata : pb_rdata_q;

endmodule

// File: tb/tb_video_vram_arbiter.sv
// Directed self-checking bench for video_vram_arbiter (BURST_LIMIT=4).
// Guard expectations follow VIDEO_VRAM_ARBITER_STARVE_GUARD_EN as defined for the build.
module tb_video_vram_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pa_request = 1'b0;
  logic        i_pa_rw = 1'b0;
  logic [31:0] i_pa_address = '0;
  logic [31:0] i_pa_wdata = '0;
  logic [31:0] o_pa_rdata;
  logic        o_pa_ready;
  logic        i_pb_request = 1'b0;
  logic [31:0] i_pb_address = '0;
  logic [31:0] o_pb_rdata;
  logic        o_pb_ready;
  logic        o_mem_request;
  logic        o_mem_rw;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_ready = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  video_vram_arbiter #(.BURST_LIMIT(4)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_pa_request  (i_pa_request),
    .i_pa_rw       (i_pa_rw),
    .i_pa_address  (i_pa_address),
    .i_pa_wdata    (i_pa_wdata),
    .o_pa_rdata    (o_pa_rdata),
    .o_pa_ready    (o_pa_ready),
    .i_pb_request  (i_pb_request),
    .i_pb_address  (i_pb_address),
    .o_pb_rdata    (o_pb_rdata),
    .o_pb_ready    (o_pb_ready),
    .o_mem_request (o_mem_request),
    .o_mem_rw      (o_mem_rw),
    .o_mem_address (o_mem_address),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_ready   (i_mem_ready)
  );

  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    int unsigned cyc;
    int unsigned last;
    logic [31:0] addr;
    logic        exp_a;
    logic        guard_on;
`ifdef VIDEO_VRAM_ARBITER_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif

    // Reset state
    do_reset();
    settle();
    check_eq("rst_mem_req", 32'(o_mem_request), 32'd0);
    check_eq("rst_pa_ready", 32'(o_pa_ready), 32'd0);
    check_eq("rst_pb_ready", 32'(o_pb_ready), 32'd0);
    check_eq("rst_pa_rdata", o_pa_rdata, 32'd0);
    check_eq("rst_pb_rdata", o_pb_rdata, 32'd0);

    // CPU write alone: grant one cycle after request, ready pulse, back to IDLE
    tick();
    i_pa_request = 1'b1; i_pa_rw = 1'b1; i_pa_address = 32'h100; i_pa_wdata = 32'hCAFE;
    settle();
    check_eq("wr_idle_req", 32'(o_mem_request), 32'd0);
    tick();
    settle();
    check_eq("wr_mem_req", 32'(o_mem_request), 32'd1);
    check_eq("wr_mem_rw", 32'(o_mem_rw), 32'd1);
    check_eq("wr_mem_addr", o_mem_address, 32'h100);
    check_eq("wr_mem_wdata", o_mem_wdata, 32'hCAFE);
    check_eq("wr_pa_ready_early", 32'(o_pa_ready), 32'd0);
    i_mem_ready = 1'b1; i_mem_rdata = 32'h1234;
    settle();
    check_eq("wr_pa_ready", 32'(o_pa_ready), 32'd1);
    check_eq("wr_pb_ready", 32'(o_pb_ready), 32'd0);
    check_eq("wr_pa_rdata", o_pa_rdata, 32'h1234);
    tick();
    i_mem_ready = 1'b0; i_pa_request = 1'b0; i_pa_rw = 1'b0; i_mem_rdata = 32'h0;
    settle();
    check_eq("wr_after_req", 32'(o_mem_request), 32'd0);
    check_eq("wr_after_ready", 32'(o_pa_ready), 32'd0);
    check_eq("wr_rdata_held", o_pa_rdata, 32'h1234);

    // Stray memory ready in IDLE is ignored
    i_mem_ready = 1'b1; i_mem_rdata = 32'h5555;
    settle();
    check_eq("idle_pa_ready", 32'(o_pa_ready), 32'd0);
    check_eq("idle_pb_ready", 32'(o_pb_ready), 32'd0);
    tick();
    i_mem_ready = 1'b0;
    settle();
    check_eq("idle_pa_rdata", o_pa_rdata, 32'h1234);
    check_eq("idle_pb_rdata", o_pb_rdata, 32'h0);
    check_eq("idle_mem_req", 32'(o_mem_request), 32'd0);

    // Simultaneous requests: pb first, pa after pb ready plus one bubble
    i_pa_request = 1'b1; i_pa_address = 32'h300; i_pa_wdata = 32'hFFFF;
    i_pb_request = 1'b1; i_pb_address = 32'h2000;
    tick();
    settle();
    check_eq("sim_b_req", 32'(o_mem_request), 32'd1);
    check_eq("sim_b_addr", o_mem_address, 32'h2000);
    check_eq("sim_b_rw", 32'(o_mem_rw), 32'd0);
    check_eq("sim_b_wdata", o_mem_wdata, 32'd0);
    i_mem_ready = 1'b1; i_mem_rdata = 32'hBEEF;
    settle();
    check_eq("sim_b_ready", 32'(o_pb_ready), 32'd1);
    check_eq("sim_b_pa_ready", 32'(o_pa_ready), 32'd0);
    check_eq("sim_b_rdata", o_pb_rdata, 32'hBEEF);
    tick();
    i_mem_ready = 1'b0; i_pb_request = 1'b0;
    settle();
    check_eq("sim_bubble", 32'(o_mem_request), 32'd0);
    tick();
    settle();
    check_eq("sim_a_req", 32'(o_mem_request), 32'd1);
    check_eq("sim_a_addr", o_mem_address, 32'h300);
    i_mem_ready = 1'b1; i_mem_rdata = 32'hA5A5;
    settle();
    check_eq("sim_a_ready", 32'(o_pa_ready), 32'd1);
    check_eq("sim_a_rdata", o_pa_rdata, 32'hA5A5);
    check_eq("sim_a_pb_rdata", o_pb_rdata, 32'hBEEF);
    tick();
    i_mem_ready = 1'b0; i_pa_request = 1'b0;

    // pb withdraws during its grant: request drops at once, IDLE next cycle
    i_pb_request = 1'b1; i_pb_address = 32'h40;
    tick();
    settle();
    check_eq("drop_granted", 32'(o_mem_request), 32'd1);
    i_pb_request = 1'b0;
    settle();
    check_eq("drop_same_cycle", 32'(o_mem_request), 32'd0);
    check_eq("drop_no_ready", 32'(o_pb_ready), 32'd0);
    tick();
    i_pa_request = 1'b1; i_pa_address = 32'h440;
    settle();
    check_eq("drop_idle", 32'(o_mem_request), 32'd0);
    tick();
    settle();
    check_eq("drop_next_a_req", 32'(o_mem_request), 32'd1);
    check_eq("drop_next_a_addr", o_mem_address, 32'h440);
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0; i_pa_request = 1'b0;

    // Reset during a pb grant; late memory ready is ignored
    i_pb_request = 1'b1; i_pb_address = 32'h80;
    tick();
    settle();
    check_eq("rstx_granted", 32'(o_mem_request), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_pb_request = 1'b0; i_mem_ready = 1'b1; i_mem_rdata = 32'h7777;
    settle();
    check_eq("rstx_mem_req", 32'(o_mem_request), 32'd0);
    check_eq("rstx_pb_ready", 32'(o_pb_ready), 32'd0);
    tick();
    i_mem_ready = 1'b0;
    settle();
    check_eq("rstx_pb_rdata", o_pb_rdata, 32'd0);
    check_eq("rstx_pa_rdata", o_pa_rdata, 32'd0);

    // Starvation guard: pb continuous, pa held, instant memory responder
    do_reset();
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h500;
    i_pb_request = 1'b1; i_pb_address = 32'h600;
    n = 0; cyc = 0;
    while (n < 12 && cyc < 200) begin
      #1;
      i_mem_ready = o_mem_request; i_mem_rdata = 32'(cyc);
      #1;
      if (o_pa_ready || o_pb_ready) begin
        exp_a = guard_on && ((n % 5) == 4);
        check_eq("guard_order", 32'(o_pa_ready), 32'(exp_a));
        check_eq("guard_exclusive", 32'(o_pa_ready & o_pb_ready), 32'd0);
        n++;
      end
      tick();
      i_mem_ready = 1'b0;
      cyc++;
    end
    check_eq("guard_count", n, 32'd12);
    i_pa_request = 1'b0; i_pb_request = 1'b0;
    do_reset();

    // 640-byte line fetch: 160 reads, address +4 per ready, one bubble between
    i_pb_request = 1'b1;
    addr = 32'h0; n = 0; cyc = 0; last = 0;
    while (n < 160 && cyc < 2000) begin
      i_pb_address = addr;
      #1;
      i_mem_ready = o_mem_request; i_mem_rdata = addr ^ 32'hA5A5_0000;
      #1;
      if (o_pb_ready) begin
        check_eq("line_addr", o_mem_address, addr);
        check_eq("line_rdata", o_pb_rdata, addr ^ 32'hA5A5_0000);
        if (n > 0) check_eq("line_gap", cyc - last, 32'd2);
        last = cyc;
        n++;
        addr = addr + 32'd4;
      end
      tick();
      i_mem_ready = 1'b0;
      cyc++;
    end
    check_eq("line_count", n, 32'd160);
    check_eq("line_last_addr", addr, 32'h280);
    i_pb_request = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
